// File: rtl/fetch_unit_pkg.sv
// Shared types and default widths for the instruction fetch front end.
package fetch_unit_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Byte distance between consecutive instruction words.
    function automatic int unsigned pc_step(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; pointers carry one
// extra wrap bit so full and empty are told apart without a separate flag.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [PTR_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (PTR_WIDTH+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue may still take a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PTR_WIDTH-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential imem requests into a prefetch queue,
// with redirect/flush. FETCH_UNIT_BYPASS_EN adds an empty-queue ack bypass.
//
// state | meaning
// FETCH | issue requests, push acked words into the queue
// DRAIN | a discarded request is still outstanding; its ack is dropped
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MEM_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
    input  logic                      redirect_i,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                      imem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                      imem_ack_i,
    output logic                      instr_valid_o,
    output logic [MEM_DATA_WIDTH-1:0] instr_o,
    output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                      instr_ready_i
);

    localparam int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_WIDTH = MEM_ADDR_WIDTH + MEM_DATA_WIDTH;
    localparam logic [MEM_ADDR_WIDTH-1:0] STEP = MEM_ADDR_WIDTH'(pc_step(MEM_DATA_WIDTH));

    fetch_state_e              state, state_next;
    logic                      req, req_next;
    logic [MEM_ADDR_WIDTH-1:0] addr, addr_next;
    logic [MEM_ADDR_WIDTH-1:0] pc, pc_next, target;
    logic [ENTRY_WIDTH-1:0]    head;
    logic [MEM_ADDR_WIDTH-1:0] head_pc;
    logic [MEM_DATA_WIDTH-1:0] head_instr;
    logic [CNT_WIDTH-1:0]      count, count_next;
    logic                      full, empty;
    logic                      accept, push, pop, issue;

    assign head_pc    = head[ENTRY_WIDTH-1:MEM_DATA_WIDTH];
    assign head_instr = head[MEM_DATA_WIDTH-1:0];
    assign accept     = imem_ack_i && req && (state == FETCH) && !redirect_i;

`ifdef FETCH_UNIT_BYPASS_EN
    logic bypass, take;

    assign bypass        = accept && empty;
    assign instr_valid_o = !empty || bypass;
    assign instr_o       = !empty ? head_instr : (bypass ? imem_rdata_i : '0);
    assign instr_pc_o    = !empty ? head_pc : (bypass ? addr : '0);
    assign take          = instr_valid_o && instr_ready_i && !redirect_i;
    assign pop           = take && !empty;
    assign push          = accept && !(bypass && take) && (!full || pop);
`else
    assign instr_valid_o = !empty;
    assign instr_o       = empty ? '0 : head_instr;
    assign instr_pc_o    = empty ? '0 : head_pc;
    assign pop           = !empty && instr_ready_i && !redirect_i;
    assign push          = accept && (!full || pop);
`endif

    fetch_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data ({addr, imem_rdata_i}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        count_next = count;
        if (redirect_i)       count_next = '0;
        else if (push && !pop) count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    // Reserving the slot at issue time means every accepted ack has room.
    assign issue  = (!req || imem_ack_i) && (count_next < CNT_WIDTH'(FIFO_DEPTH));
    assign target = redirect_i ? redirect_addr_i : pc;

    always_comb begin
        state_next = state;
        req_next   = req;
        addr_next  = addr;
        pc_next    = target;
        if (redirect_i) begin
            state_next = (req && !imem_ack_i) ? DRAIN : FETCH;
        end else if (state == DRAIN && imem_ack_i) begin
            state_next = FETCH;
        end
        if (issue) begin
            req_next  = 1'b1;
            addr_next = target;
            pc_next   = target + STEP;
        end else if (imem_ack_i) begin
            req_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
            req   <= 1'b0;
            addr  <= '0;
            pc    <= boot_addr_i;
        end else begin
            state <= state_next;
            req   <= req_next;
            addr  <= addr_next;
            pc    <= pc_next;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model plus an in-order
// program-counter scoreboard with queue occupancy and redirect bookkeeping.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] STEP  = 32'd4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] boot_addr_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ack_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk_i = ~clk_i;

    fetch_unit #(
        .MEM_ADDR_WIDTH (32),
        .MEM_DATA_WIDTH (32),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .boot_addr_i     (boot_addr_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .imem_ack_i      (imem_ack_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // reference model state
    logic [31:0] exp_pc, fetch_ptr, prev_addr;
    int          occ = 0;
    bit          discard = 0;
    bit          prev_req = 0, prev_ack = 0, prev_rst = 0;
    int          wait_cnt = 0;
    int          lat_fixed = 0;
    bit          lat_random = 0;
    int          acks_taken = 0;
    int          n_delivered = 0;

    task automatic cycle();
        bit new_req, delivered_now;
        int pre;
        new_req = imem_req_o && (!prev_req || prev_ack);
        if (new_req) wait_cnt = lat_random ? int'($urandom_range(0, 3)) : lat_fixed;
        imem_ack_i   = !rst_i && imem_req_o && (wait_cnt == 0);
        imem_rdata_i = imem_ack_i ? word_of(imem_addr_o) : $urandom;
        #1;
        if (prev_rst) begin
            check_val("rst_req_valid", {imem_req_o, instr_valid_o}, 0);
            check_val("rst_addr", imem_addr_o, 0);
            check_val("rst_instr", instr_o, 0);
            check_val("rst_pc", instr_pc_o, 0);
        end
        if (rst_i) begin
            occ = 0; discard = 0; wait_cnt = 0;
            exp_pc = boot_addr_i; fetch_ptr = boot_addr_i;
        end else begin
            if (new_req) begin
                check_val("req_addr", imem_addr_o, fetch_ptr);
                check_val("issue_room", occ < DEPTH, 1);
                fetch_ptr = fetch_ptr + STEP;
            end else if (prev_req && !prev_ack) begin
                check_val("req_hold", {imem_req_o, imem_addr_o}, {1'b1, prev_addr});
            end
`ifndef FETCH_UNIT_BYPASS_EN
            check_val("valid", instr_valid_o, occ > 0);
`endif
            delivered_now = instr_valid_o && instr_ready_i && !redirect_i;
            if (delivered_now) begin
                check_val("pc", instr_pc_o, exp_pc);
                check_val("instr", instr_o, word_of(exp_pc));
                exp_pc = exp_pc + STEP;
                n_delivered++;
            end
            pre = occ;
            if (delivered_now && pre > 0) occ--;
            if (imem_ack_i) begin
                if (discard) discard = 0;
                else if (!redirect_i) begin
                    acks_taken++;
                    if (!(delivered_now && pre == 0)) occ++;
                end
            end
            if (redirect_i) begin
                if (imem_req_o && !imem_ack_i) discard = 1;
                occ = 0;
                exp_pc = redirect_addr_i;
                fetch_ptr = redirect_addr_i;
            end
        end
        prev_req  = rst_i ? 1'b0 : imem_req_o;
        prev_ack  = imem_ack_i;
        prev_addr = imem_addr_o;
        prev_rst  = rst_i;
        if (imem_req_o && !imem_ack_i && wait_cnt > 0) wait_cnt--;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_i = 1'b1;
        redirect_i = 1'b0;
        boot_addr_i = boot;
        cycle();
        cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        int d0, base;
        bit found;
        rst_i = 1'b1; boot_addr_i = 32'h1000; redirect_i = 1'b0;
        redirect_addr_i = '0; instr_ready_i = 1'b1;
        imem_ack_i = 1'b0; imem_rdata_i = '0;
        @(posedge clk_i);
        #1;

        // zero-wait memory sustains one word per cycle
        lat_random = 0; lat_fixed = 0;
        do_reset(32'h1000);
        d0 = n_delivered;
        repeat (30) cycle();
        check_val("seq_count", n_delivered - d0, 28);

        // consumer stalled: queue fills to DEPTH and requests stop
        instr_ready_i = 1'b0;
        do_reset(32'h1000);
        base = acks_taken;
        repeat (20) cycle();
        check_val("stall_acks", acks_taken - base, DEPTH);
        check_val("stall_req", imem_req_o, 0);
        check_val("stall_valid", instr_valid_o, 1);
        instr_ready_i = 1'b1;
        d0 = n_delivered;
        repeat (6) cycle();
        check_val("stall_drain", n_delivered - d0 >= DEPTH, 1);

        // redirect while 0x1010 is pending on a 3-cycle memory
        lat_fixed = 3;
        do_reset(32'h1000);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (imem_req_o && imem_addr_o == 32'h1010) found = 1;
            else cycle();
        end
        check_val("wait_1010", found, 1);
        redirect_i = 1'b1; redirect_addr_i = 32'h2000;
        cycle();
        redirect_i = 1'b0;
        check_val("drain_hold", {imem_req_o, imem_addr_o}, {1'b1, 32'h1010});
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req_o && imem_addr_o == 32'h2000) found = 1;
            else cycle();
        end
        check_val("redir_target", found, 1);
        repeat (20) cycle();

        // redirect coincident with ack and pop
        lat_fixed = 0;
        do_reset(32'h1000);
        repeat (8) cycle();
        check_val("pre_coinc", {instr_valid_o, imem_req_o}, 2'b11);
        redirect_i = 1'b1; redirect_addr_i = 32'h3000;
        cycle();
        redirect_i = 1'b0;
        check_val("coinc_ack", prev_ack, 1);
`ifndef FETCH_UNIT_BYPASS_EN
        check_val("coinc_valid", instr_valid_o, 0);
`endif
        check_val("coinc_req", {imem_req_o, imem_addr_o}, {1'b1, 32'h3000});
        repeat (10) cycle();

        // PC wraps past the top of the address space
        do_reset(32'hFFFF_FFF8);
        d0 = n_delivered;
        repeat (10) cycle();
        check_val("wrap_count", n_delivered - d0 >= 5, 1);

        // reset asserted while a request is outstanding
        lat_fixed = 3;
        do_reset(32'h1000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req_o && wait_cnt > 0) found = 1;
            else cycle();
        end
        check_val("wait_outstanding", found, 1);
        rst_i = 1'b1; boot_addr_i = 32'h4000;
        cycle();
        rst_i = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req_o && imem_addr_o == 32'h4000) found = 1;
            else cycle();
        end
        check_val("reboot_req", found, 1);
        repeat (10) cycle();

        // random latency, backpressure and redirects
        lat_random = 1;
        do_reset(32'h1000);
        d0 = n_delivered;
        for (int i = 0; i < 2000; i++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            redirect_i = ($urandom_range(0, 24) == 0);
            redirect_addr_i = ($urandom_range(0, 7) == 0) ?
                              (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4) :
                              ($urandom & 32'hFFFF_FFFC);
            cycle();
        end
        redirect_i = 1'b0;
        instr_ready_i = 1'b1;
        repeat (10) cycle();
        check_val("rand_progress", n_delivered - d0 > 200, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
